// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace streamer.
// Holds the streamer FSM state type and the fixed frame layout constants.
package trace_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } state_e;

  // Frame layout: pc, instruction, then regfile 0..31.
  localparam int unsigned FRAME_WORDS = 34;
  localparam int unsigned WORD_PC     = 0;
  localparam int unsigned WORD_INST   = 1;
  localparam int unsigned WORD_REG0   = 2;

  // Index of the final word of a frame, sized to the word counter.
  localparam logic [5:0] LAST_WORD = 6'(FRAME_WORDS - 1);

endpackage

// File: rtl/trace_frame_streamer.sv
// Commit-trace streamer for the single-cycle MIPS54 core.
// Each committed instruction produces one 34-word frame on a valid/ready stream:
// pc, instruction word, then regfile 0..31. The core is stalled while a frame drains
// and the register file is read through a dedicated combinational debug port.
//
// Ports:
//   i_clk_in          core clock, rising edge
//   i_reset           asynchronous active-low reset
//   i_enable          tracing enable, sampled only while idle
//   i_commit_valid    instruction retires this cycle
//   i_commit_pc       pc of the retiring instruction
//   i_commit_inst     instruction word of the retiring instruction
//   o_rf_raddr        regfile debug read address
//   i_rf_rdata        regfile debug read data (same cycle)
//   o_cpu_stall       freezes core pc and regfile writes
//   o_tr_valid        o_tr_data holds a valid word
//   i_tr_ready        sink accepts the word
//   o_tr_data         registered frame word
//   o_tr_last         current word is the last of the frame
//   o_frame_cnt       number of frames fully accepted
//   o_done            frame limit reached; terminal until reset
module trace_frame_streamer
  import trace_pkg::*;
#(
  parameter int unsigned MAX_FRAMES = 2000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             i_clk_in,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_commit_valid,
  input  logic [31:0]      i_commit_pc,
  input  logic [31:0]      i_commit_inst,
  output logic [4:0]       o_rf_raddr,
  input  logic [31:0]      i_rf_rdata,
  output logic             o_cpu_stall,
  output logic             o_tr_valid,
  input  logic             i_tr_ready,
  output logic [31:0]      o_tr_data,
  output logic             o_tr_last,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_FRAMES);

  state_e             r_state,     w_state_d;
  logic               r_tr_valid,  w_tr_valid_d;
  logic [31:0]        r_tr_data,   w_tr_data_d;
  logic [5:0]         r_word_cnt,  w_word_cnt_d;
  logic [31:0]        r_inst,      w_inst_d;
  logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_d;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_below_max;
  logic [5:0]         w_word_m1;

  assign w_cnt_inc   = r_frame_cnt + CNT_W'(1);
  assign w_below_max = (MAX_FRAMES == 0) || (r_frame_cnt < MaxCnt);
  assign w_word_m1   = r_word_cnt - 6'd1;

  always_ff @(posedge i_clk_in or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_tr_valid  <= 1'b0;
      r_tr_data   <= '0;
      r_word_cnt  <= '0;
      r_inst      <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_tr_valid  <= w_tr_valid_d;
      r_tr_data   <= w_tr_data_d;
      r_word_cnt  <= w_word_cnt_d;
      r_inst      <= w_inst_d;
      r_frame_cnt <= w_frame_cnt_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_tr_valid_d  = r_tr_valid;
    w_tr_data_d   = r_tr_data;
    w_word_cnt_d  = r_word_cnt;
    w_inst_d      = r_inst;
    w_frame_cnt_d = r_frame_cnt;

    unique case (r_state)
      StIdle: begin
        if (i_enable && i_commit_valid && w_below_max) begin
          w_tr_data_d  = i_commit_pc;
          w_inst_d     = i_commit_inst;
          w_word_cnt_d = '0;
          w_tr_valid_d = 1'b1;
          w_state_d    = StSend;
        end
      end
      StSend: begin
        if (r_tr_valid && i_tr_ready) begin
          if (r_word_cnt < LAST_WORD) begin
            w_word_cnt_d = r_word_cnt + 6'd1;
            // Word 1 comes from the captured instruction; later words from the
            // register prefetched via o_rf_raddr.
            w_tr_data_d  = (r_word_cnt == 6'(WORD_PC)) ? r_inst : i_rf_rdata;
          end else begin
            w_tr_valid_d  = 1'b0;
            w_frame_cnt_d = w_cnt_inc;
            w_state_d     = ((MAX_FRAMES != 0) && (w_cnt_inc == MaxCnt)) ? StDone : StIdle;
          end
        end
      end
      StDone: begin
        w_state_d = StDone;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // While word N is on the bus, read register N-1 so it is ready for word N+1.
  assign o_rf_raddr  = (r_state == StSend) ? w_word_m1[4:0] : 5'd0;
  assign o_cpu_stall = (r_state == StSend);
  assign o_tr_valid  = r_tr_valid;
  assign o_tr_data   = r_tr_data;
  assign o_tr_last   = r_tr_valid && (r_word_cnt == LAST_WORD);
  assign o_frame_cnt = r_frame_cnt;
  assign o_done      = (r_state == StDone);

endmodule
